// File: rtl/alu_issue_ctrl.sv
// Issue controller between a MIPS-style decoder and an external combinational ALU.
// Accepts one instruction, drives the ALU, waits WAIT_CYCLES edges, then holds the result until taken.
module alu_issue_ctrl #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic [15:0] imm,
  input  logic [4:0]  shamt,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  output logic [3:0]  alu_operation,
  output logic [4:0]  alu_shmt,
  input  logic [31:0] alu_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        zero,
  output logic        branch_taken,
  output logic        illegal
);

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
  typedef enum logic [1:0] {BR_NONE, BR_EQ, BR_NE} br_kind_t;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [4:0]  shmt;
    br_kind_t    br;
    logic        ill;
  } dec_t;

  state_t      state, state_nxt;
  dec_t        dec;
  logic [3:0]  cnt;
  br_kind_t    br_q;
  logic        ill_q;
  logic        accept;
  logic        capture;
  logic [31:0] cap_val;
  logic        cap_zero;

  logic [31:0] sext_imm;
  logic [31:0] zext_imm;
  logic        legal;

  assign sext_imm = {{16{imm[15]}}, imm};
  assign zext_imm = {16'h0000, imm};

  // Instruction decode. Unlisted encodings collapse to an all-zero ALU drive.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    dec       = '0;
    legal     = 1'b1;
    dec.in1   = rs_val;
    dec.in2   = rt_val;
    if (opcode == 6'h00) begin
      case (funct)
        6'h20, 6'h21: dec.op = ALU_ADD;
        6'h22, 6'h23: dec.op = ALU_SUB;
        6'h24:        dec.op = ALU_AND;
        6'h25:        dec.op = ALU_OR;
        6'h27:        dec.op = ALU_NOR;
        6'h2A:        dec.op = ALU_SLT;
        6'h00: begin
          dec.op   = ALU_SLL;
          dec.shmt = shamt;
        end
        default:      legal = 1'b0;
      endcase
    end else begin
      case (opcode)
        6'h08, 6'h09, 6'h23, 6'h2B: begin
          dec.op  = ALU_ADD;
          dec.in2 = sext_imm;
        end
        6'h0A: begin
          dec.op  = ALU_SLT;
          dec.in2 = sext_imm;
        end
        6'h0C: begin
          dec.op  = ALU_AND;
          dec.in2 = zext_imm;
        end
        6'h0D: begin
          dec.op  = ALU_OR;
          dec.in2 = zext_imm;
        end
        6'h04: begin
          dec.op = ALU_SUB;
          dec.br = BR_EQ;
        end
        6'h05: begin
          dec.op = ALU_SUB;
          dec.br = BR_NE;
        end
        default: legal = 1'b0;
      endcase
    end
    if (!legal) begin
      dec     = '0;
      dec.ill = 1'b1;
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign accept    = in_valid && (state == S_IDLE);
  assign capture   = (state == S_WAIT) && (cnt == 4'd1);
  assign cap_val   = ill_q ? 32'h0 : alu_out;
  assign cap_zero  = (cap_val == 32'h0);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (in_valid)  state_nxt = S_WAIT;
      S_WAIT:  if (cnt == 4'd1) state_nxt = S_DONE;
      S_DONE:  if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // A reset mid-flight clears every register, so the abandoned instruction leaves no trace.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alu_in1       <= '0;
      alu_in2       <= '0;
      alu_operation <= '0;
      alu_shmt      <= '0;
      cnt           <= '0;
      br_q          <= BR_NONE;
      ill_q         <= 1'b0;
      result        <= '0;
      zero          <= 1'b0;
      branch_taken  <= 1'b0;
      illegal       <= 1'b0;
    end else begin
      if (accept) begin
        alu_in1       <= dec.in1;
        alu_in2       <= dec.in2;
        alu_operation <= dec.op;
        alu_shmt      <= dec.shmt;
        br_q          <= dec.br;
        ill_q         <= dec.ill;
        cnt           <= WAIT_LOAD;
      end else if (state == S_WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (capture) begin
        result       <= cap_val;
        zero         <= cap_zero;
        illegal      <= ill_q;
        branch_taken <= ((br_q == BR_EQ) && cap_zero) || ((br_q == BR_NE) && !cap_zero);
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed table, hand sequences for reset/backpressure,
// and randomized instructions checked against an architectural result model.
module tb_alu_issue_ctrl;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [15:0] imm;
    logic [4:0]  shamt;
  } in_t;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [4:0]  shmt;
    logic [31:0] result;
    logic        zero;
    logic        br;
    logic        ill;
  } exp_t;

  typedef struct packed {
    in_t  i;
    exp_t e;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, out_ready;
  logic [5:0]  opcode, funct;
  logic [31:0] rs_val, rt_val;
  logic [15:0] imm;
  logic [4:0]  shamt;

  logic        in_ready, out_valid, zero, branch_taken, illegal;
  logic [31:0] alu_in1, alu_in2, alu_out, result;
  logic [3:0]  alu_operation;
  logic [4:0]  alu_shmt;

  logic        in_ready1, out_valid1, zero1, branch_taken1, illegal1;
  logic [31:0] alu_in1_1, alu_in2_1, alu_out1, result1;
  logic [3:0]  alu_operation1;
  logic [4:0]  alu_shmt1;

  int n_vec = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  // Stand-in for the external ALU, by operation name.
  function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] sh);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1100: return ~(a | b);
      4'b0011: return b << sh;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  assign alu_out  = alu_model(alu_operation, alu_in1, alu_in2, alu_shmt);
  assign alu_out1 = alu_model(alu_operation1, alu_in1_1, alu_in2_1, alu_shmt1);

  alu_issue_ctrl #(.WAIT_CYCLES(2)) u_dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct(funct), .rs_val(rs_val), .rt_val(rt_val), .imm(imm), .shamt(shamt),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_operation(alu_operation), .alu_shmt(alu_shmt),
    .alu_out(alu_out), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .branch_taken(branch_taken), .illegal(illegal)
  );

  alu_issue_ctrl #(.WAIT_CYCLES(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready1),
    .opcode(opcode), .funct(funct), .rs_val(rs_val), .rt_val(rt_val), .imm(imm), .shamt(shamt),
    .alu_in1(alu_in1_1), .alu_in2(alu_in2_1), .alu_operation(alu_operation1), .alu_shmt(alu_shmt1),
    .alu_out(alu_out1), .out_valid(out_valid1), .out_ready(out_ready), .result(result1),
    .zero(zero1), .branch_taken(branch_taken1), .illegal(illegal1)
  );

  // Architectural reference: what the instruction means, computed directly from its operands.
  function automatic exp_t ref_fn(input in_t v);
    exp_t        e;
    logic [31:0] sx, zx;
    logic        ok;
    sx = {{16{v.imm[15]}}, v.imm};
    zx = {16'h0, v.imm};
    e  = '0;
    ok = 1'b1;
    e.in1 = v.rs;
    e.in2 = v.rt;
    if (v.opcode == 6'h00) begin
      case (v.funct)
        6'h20, 6'h21: begin e.op = 4'b0010; e.result = v.rs + v.rt; end
        6'h22, 6'h23: begin e.op = 4'b0110; e.result = v.rs - v.rt; end
        6'h24:        begin e.op = 4'b0000; e.result = v.rs & v.rt; end
        6'h25:        begin e.op = 4'b0001; e.result = v.rs | v.rt; end
        6'h27:        begin e.op = 4'b1100; e.result = ~(v.rs | v.rt); end
        6'h2A:        begin e.op = 4'b0111; e.result = {31'b0, $signed(v.rs) < $signed(v.rt)}; end
        6'h00:        begin e.op = 4'b0011; e.shmt = v.shamt; e.result = v.rt << v.shamt; end
        default:      ok = 1'b0;
      endcase
    end else begin
      case (v.opcode)
        6'h08, 6'h09, 6'h23, 6'h2B: begin e.op = 4'b0010; e.in2 = sx; e.result = v.rs + sx; end
        6'h0A: begin e.op = 4'b0111; e.in2 = sx; e.result = {31'b0, $signed(v.rs) < $signed(sx)}; end
        6'h0C: begin e.op = 4'b0000; e.in2 = zx; e.result = v.rs & zx; end
        6'h0D: begin e.op = 4'b0001; e.in2 = zx; e.result = v.rs | zx; end
        6'h04: begin e.op = 4'b0110; e.result = v.rs - v.rt; e.br = (v.rs == v.rt); end
        6'h05: begin e.op = 4'b0110; e.result = v.rs - v.rt; e.br = (v.rs != v.rt); end
        default: ok = 1'b0;
      endcase
    end
    if (!ok) begin
      e     = '0;
      e.ill = 1'b1;
    end
    e.zero = (e.result == 32'h0);
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input in_t v);
    opcode = v.opcode;
    funct  = v.funct;
    rs_val = v.rs;
    rt_val = v.rt;
    imm    = v.imm;
    shamt  = v.shamt;
  endtask

  task automatic scramble();
    opcode = 6'($urandom);
    funct  = 6'($urandom);
    rs_val = $urandom;
    rt_val = $urandom;
    imm    = 16'($urandom);
    shamt  = 5'($urandom);
  endtask

  // Starts just before the accepting edge with in_valid and fields already driven.
  task automatic complete_op(input exp_t e, input int hold, input bit noisy,
                             input bit chain, input in_t nxt);
    int lat0, lat1, k;
    @(posedge clk); #1;
    check("accept_in_ready", in_ready, 0);
    check("alu_operation", alu_operation, e.op);
    check("alu_in1", alu_in1, e.in1);
    check("alu_in2", alu_in2, e.in2);
    check("alu_shmt", alu_shmt, e.shmt);
    in_valid = noisy;
    if (noisy) scramble();
    lat0 = 0; lat1 = 0; k = 0;
    while (lat0 == 0 && k < 40) begin
      @(posedge clk); #1;
      k++;
      if (out_valid1 && lat1 == 0) lat1 = k;
      if (out_valid && lat0 == 0) lat0 = k;
      if (noisy) scramble();
    end
    check("latency_w2", lat0, 2);
    check("latency_w1", lat1, 1);
    check("result", result, e.result);
    check("zero", zero, e.zero);
    check("branch_taken", branch_taken, e.br);
    check("illegal", illegal, e.ill);
    check("result_w1", result1, e.result);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("hold_out_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_result", result, e.result);
      check("hold_flags", {zero, branch_taken, illegal}, {e.zero, e.br, e.ill});
      if (noisy) scramble();
    end
    in_valid = chain;
    if (chain) drive(nxt);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("release_out_valid", out_valid, 0);
    check("release_in_ready", in_ready, 1);
    check("release_in_ready_w1", in_ready1, 1);
  endtask

  task automatic run_op(input in_t v, input exp_t e, input int hold, input bit noisy);
    @(negedge clk);
    check("idle_in_ready", in_ready, 1);
    drive(v);
    in_valid = 1'b1;
    complete_op(e, hold, noisy, 1'b0, v);
  endtask

  task automatic watch_silent(input string name, input int cycles);
    int seen = 0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      if (out_valid || out_valid1) seen++;
    end
    check(name, seen, 0);
  endtask

  vec_t vecs[17];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    in_t  ri, ri2;
    exp_t re;

    vecs[0]  = '{'{6'h00, 6'h20, 32'd5, 32'd7, 16'h0, 5'd0},
                 '{4'b0010, 32'd5, 32'd7, 5'd0, 32'd12, 1'b0, 1'b0, 1'b0}};
    vecs[1]  = '{'{6'h04, 6'h00, 32'h1234, 32'h1234, 16'h0003, 5'd0},
                 '{4'b0110, 32'h1234, 32'h1234, 5'd0, 32'h0, 1'b1, 1'b1, 1'b0}};
    vecs[2]  = '{'{6'h05, 6'h00, 32'h1234, 32'h1234, 16'h0003, 5'd0},
                 '{4'b0110, 32'h1234, 32'h1234, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0}};
    vecs[3]  = '{'{6'h08, 6'h00, 32'd1, 32'd0, 16'hFFFF, 5'd0},
                 '{4'b0010, 32'd1, 32'hFFFF_FFFF, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0}};
    vecs[4]  = '{'{6'h0C, 6'h00, 32'h1234_5678, 32'd0, 16'hFFFF, 5'd0},
                 '{4'b0000, 32'h1234_5678, 32'h0000_FFFF, 5'd0, 32'h0000_5678, 1'b0, 1'b0, 1'b0}};
    vecs[5]  = '{'{6'h00, 6'h00, 32'd0, 32'd1, 16'h0, 5'd4},
                 '{4'b0011, 32'd0, 32'd1, 5'd4, 32'h10, 1'b0, 1'b0, 1'b0}};
    vecs[6]  = '{'{6'h00, 6'h3F, 32'd5, 32'd7, 16'h0, 5'd0},
                 '{4'b0000, 32'd0, 32'd0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b1}};
    vecs[7]  = '{'{6'h3F, 6'h20, 32'd5, 32'd7, 16'h1234, 5'd3},
                 '{4'b0000, 32'd0, 32'd0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b1}};
    vecs[8]  = '{'{6'h00, 6'h2A, 32'hFFFF_FFFF, 32'd1, 16'h0, 5'd0},
                 '{4'b0111, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd1, 1'b0, 1'b0, 1'b0}};
    vecs[9]  = '{'{6'h0A, 6'h00, 32'd5, 32'd0, 16'h8000, 5'd0},
                 '{4'b0111, 32'd5, 32'hFFFF_8000, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0}};
    vecs[10] = '{'{6'h0D, 6'h00, 32'hF000_0000, 32'd0, 16'h8001, 5'd0},
                 '{4'b0001, 32'hF000_0000, 32'h0000_8001, 5'd0, 32'hF000_8001, 1'b0, 1'b0, 1'b0}};
    vecs[11] = '{'{6'h00, 6'h27, 32'd0, 32'hFFFF_0000, 16'h0, 5'd0},
                 '{4'b1100, 32'd0, 32'hFFFF_0000, 5'd0, 32'h0000_FFFF, 1'b0, 1'b0, 1'b0}};
    vecs[12] = '{'{6'h00, 6'h23, 32'd3, 32'd5, 16'h0, 5'd31},
                 '{4'b0110, 32'd3, 32'd5, 5'd0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0}};
    vecs[13] = '{'{6'h05, 6'h00, 32'd1, 32'd2, 16'h0, 5'd0},
                 '{4'b0110, 32'd1, 32'd2, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0}};
    vecs[14] = '{'{6'h23, 6'h00, 32'h100, 32'd0, 16'hFFFC, 5'd0},
                 '{4'b0010, 32'h100, 32'hFFFF_FFFC, 5'd0, 32'hFC, 1'b0, 1'b0, 1'b0}};
    vecs[15] = '{'{6'h00, 6'h00, 32'd0, 32'd3, 16'h0, 5'd31},
                 '{4'b0011, 32'd0, 32'd3, 5'd31, 32'h8000_0000, 1'b0, 1'b0, 1'b0}};
    vecs[16] = '{'{6'h00, 6'h25, 32'd0, 32'd0, 16'h0, 5'd0},
                 '{4'b0001, 32'd0, 32'd0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0}};

    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    opcode = '0; funct = '0; rs_val = '0; rt_val = '0; imm = '0; shamt = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_alu_drive", {alu_in1 | alu_in2, 1'b0}, 0);
    check("rst_alu_op_shmt", {alu_operation, alu_shmt}, 0);
    check("rst_flags", {zero, branch_taken, illegal}, 0);

    for (int n = 0; n < 17; n++)
      run_op(vecs[n].i, vecs[n].e, n % 3, n[0]);

    // Long backpressure with a competing in_valid that must be ignored.
    run_op(vecs[0].i, vecs[0].e, 5, 1'b1);

    // in_valid held through the release edge: no accept there, accept one edge later.
    @(negedge clk);
    drive(vecs[13].i);
    in_valid = 1'b1;
    complete_op(vecs[13].e, 1, 1'b0, 1'b1, vecs[4].i);
    complete_op(vecs[4].e, 0, 1'b0, 1'b0, vecs[4].i);

    // Reset during WAIT.
    @(negedge clk);
    drive(vecs[0].i);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("rst_wait_out_valid", out_valid, 0);
    check("rst_wait_in_ready", in_ready, 1);
    check("rst_wait_alu_drive", alu_in1 | alu_in2, 0);
    check("rst_wait_alu_op", alu_operation, 0);
    check("rst_wait_result", result, 0);
    @(negedge clk);
    reset_n = 1'b1;
    watch_silent("rst_wait_no_out_valid", 6);
    run_op(vecs[1].i, vecs[1].e, 0, 1'b0);

    // Reset during DONE on an illegal op: flags must clear.
    @(negedge clk);
    drive(vecs[6].i);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_done_out_valid", out_valid, 1);
    reset_n = 1'b0;
    #1;
    check("rst_done_out_valid", out_valid, 0);
    check("rst_done_flags", {zero, branch_taken, illegal}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    watch_silent("rst_done_no_out_valid", 6);

    // in_valid high on the first edge after reset release.
    @(negedge clk);
    reset_n = 1'b0;
    #2;
    drive(vecs[10].i);
    in_valid = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    complete_op(vecs[10].e, 0, 1'b0, 1'b0, vecs[10].i);

    // Randomized instructions against the architectural model.
    for (int n = 0; n < 200; n++) begin
      logic [5:0] r_ops[10];
      logic [5:0] r_fns[10];
      r_ops = '{6'h00, 6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h04, 6'h05, 6'h23, 6'h2B};
      r_fns = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h00, 6'h3F};
      ri.opcode = ($urandom_range(0, 3) == 0) ? 6'h00 : r_ops[$urandom_range(0, 9)];
      if ($urandom_range(0, 15) == 0) ri.opcode = 6'($urandom);
      ri.funct = r_fns[$urandom_range(0, 9)];
      if ($urandom_range(0, 15) == 0) ri.funct = 6'($urandom);
      ri.rs    = $urandom;
      ri.rt    = ($urandom_range(0, 3) == 0) ? ri.rs : $urandom;
      if ($urandom_range(0, 7) == 0) ri.rt = 32'h0;
      ri.imm   = 16'($urandom);
      ri.shamt = 5'($urandom);
      re = ref_fn(ri);
      ri2 = ri;
      run_op(ri2, re, $urandom_range(0, 3), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, cycles allowed for ALU settling (legal range 1..15).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid / in_ready  input / output  1 / 1  instruction handshake; transfer when both high at a clk edge.
REQ-005 opcode, funct  input  6 each  MIPS opcode and funct fields.
REQ-006 rs_val, rt_val  input  32 each  register operands; imm  input  16  immediate; shamt  input  5  shift amount.
REQ-007 alu_in1, alu_in2  output  32 each; alu_operation  output  4; alu_shmt  output  5  registered drive to ALU.
REQ-008 alu_out  input  32  ALU result.
REQ-009 out_valid / out_ready  output / input  1 / 1  result handshake.
REQ-010 result  output  32; zero  output  1; branch_taken  output  1; illegal  output  1.

Function
REQ-011 States IDLE, WAIT, DONE; in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-012 IDLE -> WAIT on accepted transfer; operands, alu_operation, alu_shmt registered on that edge; wait counter loaded with WAIT_CYCLES.
REQ-013 WAIT: counter decrements each edge; on edge where counter==1, capture result=alu_out, enter DONE; out_valid rises exactly WAIT_CYCLES edges after the accepting edge.
REQ-014 DONE: result, zero, branch_taken, illegal held stable until out_valid&&out_ready edge, then -> IDLE; no new accept on that same edge.
REQ-015 in_valid while not IDLE SHALL be ignored; input fields sampled only on accepting edge.
REQ-016 R-type (opcode 0x00) funct decode: 0x20/0x21 ->0010; 0x22/0x23 ->0110; 0x24 ->0000; 0x25 ->0001; 0x27 ->1100; 0x2A ->0111; 0x00 ->0011 (alu_in2=rt_val, alu_shmt=shamt); alu_in1=rs_val, alu_in2=rt_val otherwise.
REQ-017 I-type decode, alu_in1=rs_val: 0x08/0x09/0x23/0x2B ->0010 with sign-extended imm; 0x0A ->0111 sign-extended; 0x0C ->0000 and 0x0D ->0001 zero-extended; 0x04/0x05 ->0110 with alu_in2=rt_val.
REQ-018 alu_shmt SHALL be 0 for all non-shift operations.
REQ-019 zero SHALL be computed by this block as (captured result == 0) for every operation, not only subtract.
REQ-020 branch_taken = zero for opcode 0x04, !zero for 0x05, 0 otherwise.
REQ-021 Unlisted opcode/funct: illegal=1, alu_operation=0000, alu_in1=alu_in2=0, result forced 0, zero=1, branch_taken=0; same latency as legal ops.
REQ-022 Arithmetic is 32-bit modulo; no overflow flag; add/addu and sub/subu behave identically.

Reset
REQ-023 reset_n low SHALL immediately force state IDLE, in_ready=1 after release, out_valid=0, all data outputs and ALU drive outputs 0, counter 0.
REQ-024 Reset asserted mid-WAIT or mid-DONE SHALL discard the in-flight instruction; no out_valid after release without a new accept.
REQ-025 in_valid high during the first edge after reset_n release SHALL be accepted normally.

Verification
REQ-026 add: opcode 0x00, funct 0x20, rs=5, rt=7, WAIT_CYCLES=2 -> alu_operation=0010; out_valid 2 edges after accept; result=12, zero=0.
REQ-027 beq: opcode 0x04, rs=rt=0x1234 -> alu_operation=0110, result=0, zero=1, branch_taken=1; bne same operands -> branch_taken=0.
REQ-028 addi: imm=0xFFFF, rs=1 -> alu_in2=0xFFFFFFFF, result=0, zero=1; andi imm=0xFFFF, rs=0x12345678 -> alu_in2=0x0000FFFF, result=0x00005678.
REQ-029 sll: funct 0x00, rt=1, shamt=4 -> alu_shmt=4, result=0x10; illegal funct 0x3F -> illegal=1, result=0.
REQ-030 Backpressure: out_ready low 5 cycles -> outputs stable, in_ready=0, second in_valid ignored; out_ready high -> IDLE next edge.
REQ-031 reset_n pulsed low during WAIT -> out_valid never asserts for that instruction; outputs 0; next instruction completes normally.
